lab3_cache_cache_assoc_ctrl: RTL and testbench

//   Control unit for a parametrised N-way set-associative, write-back, write-allocate cache.
//   - Sits between the processor memreq/memresp val/rdy port and the multi-word memory port.
//   - Drives per-way tag/data/dirty array enables and keeps valid + tree-PLRU state internally.
//   - Sequences multi-word eviction and refill with beat counters; replays the request after refill.

---
 rtl/lab3_cache_cache_assoc_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_lab3_cache_cache_assoc_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/lab3_cache_cache_assoc_ctrl.sv
// lab3_cache_cache_assoc_ctrl: control FSM for an N-way set-associative write-back cache
//   clk, reset (sync, active-low)
//   memreq_*  : processor request (val/rdy, type, set index)
//   memresp_* : processor response (val/rdy)
//   way_hit, way_dirty : per-way tag compare / dirty bit of the latched set
//   tarray_wen, darray_wen, darray_word_sel, darray_src_mem, dirty_wen, dirty_wdata, way_sel : array controls
//   mem_req_*, mem_resp_* : multi-word memory port (val/rdy, type 0=read 1=write)
module lab3_cache_cache_assoc_ctrl #(
    parameter int NUM_WAYS = 2,
    parameter int NUM_SETS = 16,
    parameter int WORDS_PER_LINE = 4,
    localparam int IDX_W = $clog2(NUM_SETS),
    localparam int WAY_W = $clog2(NUM_WAYS),
    localparam int CNT_W = $clog2(WORDS_PER_LINE) + 1,
    localparam int SEL_W = (CNT_W > 1) ? CNT_W - 1 : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                memreq_val,
    output logic                memreq_rdy,
    input  logic                memreq_type,
    input  logic [IDX_W-1:0]    memreq_idx,
    output logic                memresp_val,
    input  logic                memresp_rdy,
    input  logic [NUM_WAYS-1:0] way_hit,
    input  logic [NUM_WAYS-1:0] way_dirty,
    output logic [NUM_WAYS-1:0] tarray_wen,
    output logic [NUM_WAYS-1:0] darray_wen,
    output logic [SEL_W-1:0]    darray_word_sel,
    output logic                darray_src_mem,
    output logic                dirty_wen,
    output logic                dirty_wdata,
    output logic [WAY_W-1:0]    way_sel,
    output logic                mem_req_val,
    input  logic                mem_req_rdy,
    output logic                mem_req_type,
    input  logic                mem_resp_val,
    output logic                mem_resp_rdy
);
    localparam int PL_W = NUM_WAYS - 1;
    localparam logic [CNT_W-1:0] WPL = CNT_W'(WORDS_PER_LINE);
    localparam logic [CNT_W-1:0] WPL_M1 = CNT_W'(WORDS_PER_LINE - 1);
    localparam logic [NUM_WAYS-1:0] WAY_ONE = NUM_WAYS'(1);
    localparam logic [PL_W-1:0] PL_ONE = PL_W'(1);

    typedef enum logic [2:0] {IDLE, TAG, EVICT, REFILL, RESP} state_t;

    state_t               state, state_n;
    logic                 type_q;
    logic [IDX_W-1:0]     idx_q;
    logic [WAY_W-1:0]     victim_q, victim, hit_way;
    logic [CNT_W-1:0]     req_cnt, resp_cnt;
    logic [NUM_WAYS-1:0]  valid [NUM_SETS];
    logic [PL_W-1:0]      plru [NUM_SETS];
    logic [NUM_WAYS-1:0]  set_valid, hit_vec;
    logic                 hit, cnt_clr, fill_done;

    function automatic logic [WAY_W-1:0] low_idx(input logic [NUM_WAYS-1:0] v);
        low_idx = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--)
            if (v[i]) low_idx = WAY_W'(i);
    endfunction

    // Heap-ordered tree: node n has children 2n+1 / 2n+2; bit 1 means the victim lies right.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PL_W-1:0] t);
        logic b;
        int   n;
        plru_victim = '0;
        n = 0;
        for (int l = 0; l < WAY_W; l++) begin
            b = |((t >> n) & PL_ONE);
            plru_victim = (plru_victim << 1) | WAY_W'(b);
            n = 2 * n + 1 + int'(b);
        end
    endfunction

    function automatic logic [PL_W-1:0] plru_touch(input logic [PL_W-1:0] t, input logic [WAY_W-1:0] w);
        logic            d;
        logic [PL_W-1:0] m;
        int              n;
        plru_touch = t;
        n = 0;
        for (int l = 0; l < WAY_W; l++) begin
            d = |((w >> (WAY_W - 1 - l)) & WAY_W'(1));
            m = PL_ONE << n;
            plru_touch = d ? (plru_touch & ~m) : (plru_touch | m);
            n = 2 * n + 1 + int'(d);
        end
    endfunction

    assign set_valid = valid[idx_q];
    assign hit_vec   = way_hit & set_valid;
    assign hit       = |hit_vec;
    assign hit_way   = low_idx(hit_vec);
    assign victim    = (&set_valid) ? plru_victim(plru[idx_q]) : low_idx(~set_valid);

    // Outputs are forced quiet while reset is held so an abandoned refill writes nothing.
    always_comb begin
        state_n         = state;
        memreq_rdy      = 1'b0;
        memresp_val     = 1'b0;
        tarray_wen      = '0;
        darray_wen      = '0;
        darray_word_sel = '0;
        darray_src_mem  = 1'b0;
        dirty_wen       = 1'b0;
        dirty_wdata     = 1'b0;
        way_sel         = '0;
        mem_req_val     = 1'b0;
        mem_req_type    = 1'b0;
        mem_resp_rdy    = !reset || state == IDLE || state == EVICT || state == REFILL;
        cnt_clr         = 1'b0;
        fill_done       = 1'b0;
        if (reset) begin
            case (state)
                IDLE: begin
                    memreq_rdy = 1'b1;
                    state_n    = memreq_val ? TAG : IDLE;
                end
                TAG: begin
                    way_sel     = hit ? hit_way : victim;
                    darray_wen  = {NUM_WAYS{hit && type_q}} & (WAY_ONE << hit_way);
                    dirty_wen   = hit && type_q;
                    dirty_wdata = hit && type_q;
                    state_n     = hit ? RESP : (set_valid[victim] && way_dirty[victim]) ? EVICT : REFILL;
                end
                EVICT: begin
                    mem_req_val     = req_cnt != WPL;
                    mem_req_type    = 1'b1;
                    darray_word_sel = req_cnt[SEL_W-1:0];
                    way_sel         = victim_q;
                    cnt_clr         = resp_cnt == WPL;
                    state_n         = cnt_clr ? REFILL : EVICT;
                end
                REFILL: begin
                    mem_req_val     = req_cnt != WPL;
                    way_sel         = victim_q;
                    darray_src_mem  = 1'b1;
                    darray_word_sel = resp_cnt[SEL_W-1:0];
                    darray_wen      = {NUM_WAYS{mem_resp_val}} & (WAY_ONE << victim_q);
                    fill_done       = mem_resp_val && resp_cnt == WPL_M1;
                    tarray_wen      = {NUM_WAYS{fill_done}} & (WAY_ONE << victim_q);
                    dirty_wen       = fill_done;
                    cnt_clr         = fill_done;
                    state_n         = fill_done ? TAG : REFILL;
                end
                RESP: begin
                    memresp_val = 1'b1;
                    state_n     = memresp_rdy ? IDLE : RESP;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            type_q   <= 1'b0;
            idx_q    <= '0;
            victim_q <= '0;
            req_cnt  <= '0;
            resp_cnt <= '0;
            for (int i = 0; i < NUM_SETS; i++) begin
                valid[i] <= '0;
                plru[i]  <= '0;
            end
        end else begin
            state <= state_n;
            if (state == IDLE && memreq_val) begin
                type_q <= memreq_type;
                idx_q  <= memreq_idx;
            end
            if (state == TAG && !hit) victim_q <= victim;
            if (state == TAG && hit) plru[idx_q] <= plru_touch(plru[idx_q], hit_way);
            if (cnt_clr) begin
                req_cnt  <= '0;
                resp_cnt <= '0;
            end else if (state == EVICT || state == REFILL) begin
                req_cnt  <= req_cnt + CNT_W'(mem_req_val && mem_req_rdy);
                resp_cnt <= resp_cnt + CNT_W'(mem_resp_val);
            end
            if (fill_done) valid[idx_q][victim_q] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_lab3_cache_cache_assoc_ctrl.sv
// tb_lab3_cache_cache_assoc_ctrl: directed bench for the 2-way, 16-set, 4-word cache controller
module tb_lab3_cache_cache_assoc_ctrl;
    logic       clk, reset;
    logic       memreq_val, memreq_rdy, memreq_type;
    logic [3:0] memreq_idx;
    logic       memresp_val, memresp_rdy;
    logic [1:0] way_hit, way_dirty, tarray_wen, darray_wen;
    logic [1:0] darray_word_sel;
    logic       darray_src_mem, dirty_wen, dirty_wdata;
    logic [0:0] way_sel;
    logic       mem_req_val, mem_req_rdy, mem_req_type, mem_resp_val, mem_resp_rdy;
    int         n_chk = 0;
    int         n_fail = 0;

    lab3_cache_cache_assoc_ctrl dut (
        .clk(clk), .reset(reset),
        .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_type(memreq_type), .memreq_idx(memreq_idx),
        .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
        .way_hit(way_hit), .way_dirty(way_dirty),
        .tarray_wen(tarray_wen), .darray_wen(darray_wen), .darray_word_sel(darray_word_sel),
        .darray_src_mem(darray_src_mem), .dirty_wen(dirty_wen), .dirty_wdata(dirty_wdata), .way_sel(way_sel),
        .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_type(mem_req_type),
        .mem_resp_val(mem_resp_val), .mem_resp_rdy(mem_resp_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic req(input logic t, input logic [3:0] idx);
        memreq_val  = 1'b1;
        memreq_type = t;
        memreq_idx  = idx;
        #1 chk("accept_rdy", memreq_rdy, 1);
        tick;
        memreq_val = 1'b0;
    endtask

    task automatic resp_step(input string nm);
        memresp_rdy = 1'b1;
        #1 chk({nm, "_resp_val"}, memresp_val, 1);
        chk({nm, "_resp_reqrdy"}, memreq_rdy, 0);
        tick;
        memresp_rdy = 1'b0;
        #1 chk({nm, "_idle_val"}, memresp_val, 0);
        chk({nm, "_idle_rdy"}, memreq_rdy, 1);
    endtask

    // Memory stand-in: answers each accepted request dly cycles later; optional toggling mem_req_rdy.
    task automatic run_mem(input string nm, input logic wr, input int way, input logic tog, input int dly);
        int         due[$];
        int         nreq, nresp;
        logic [1:0] wexp;
        wexp  = 2'b01 << way;
        nreq  = 0;
        nresp = 0;
        for (int c = 0; c < 40 && nresp < 4; c++) begin
            mem_req_rdy  = tog ? c[0] : 1'b1;
            mem_resp_val = due.size() > 0 && due[0] <= c;
            #1 chk({nm, "_way_sel"}, way_sel, way);
            chk({nm, "_resp_rdy"}, mem_resp_rdy, 1);
            if (mem_req_val) begin
                chk({nm, "_req_type"}, mem_req_type, wr);
                if (wr) chk({nm, "_evict_word"}, darray_word_sel, nreq);
            end
            if (mem_resp_val && !wr) begin
                chk({nm, "_beat_wen"}, darray_wen, wexp);
                chk({nm, "_beat_word"}, darray_word_sel, nresp);
                chk({nm, "_beat_src"}, darray_src_mem, 1);
                chk({nm, "_beat_twen"}, tarray_wen, nresp == 3 ? wexp : 2'b00);
                chk({nm, "_beat_dwen"}, dirty_wen, nresp == 3);
                chk({nm, "_beat_dwdata"}, dirty_wdata, 0);
            end else begin
                chk({nm, "_idle_wen"}, darray_wen, 0);
                chk({nm, "_idle_twen"}, tarray_wen, 0);
            end
            if (mem_req_val && mem_req_rdy) begin
                nreq++;
                due.push_back(c + dly);
            end
            if (mem_resp_val) begin
                void'(due.pop_front());
                nresp++;
            end
            tick;
        end
        mem_req_rdy  = 1'b0;
        mem_resp_val = 1'b0;
        chk({nm, "_nreq"}, nreq, 4);
        chk({nm, "_nresp"}, nresp, 4);
    endtask

    initial begin
        reset = 1'b0; memreq_val = 1'b0; memreq_type = 1'b0; memreq_idx = '0; memresp_rdy = 1'b0;
        way_hit = '0; way_dirty = '0; mem_req_rdy = 1'b0; mem_resp_val = 1'b0;
        tick;
        chk("rst_mem_resp_rdy", mem_resp_rdy, 1);
        chk("rst_memreq_rdy", memreq_rdy, 0);
        chk("rst_mem_req_val", mem_req_val, 0);
        tick;
        chk("rst_darray_wen", darray_wen, 0);
        chk("rst_memresp_val", memresp_val, 0);
        reset = 1'b1;
        #1 chk("idle_memreq_rdy", memreq_rdy, 1);
        tick;
        chk("idle_mem_req_val", mem_req_val, 0);
        chk("idle_mem_resp_rdy", mem_resp_rdy, 1);

        // 1: clean read miss on idx 3 fills way0, replay hits
        req(1'b0, 4'd3);
        way_hit = 2'b01;
        #1 chk("t1_tag_reqval", mem_req_val, 0);
        chk("t1_tag_memreq_rdy", memreq_rdy, 0);
        chk("t1_tag_wen", darray_wen, 0);
        tick;
        run_mem("t1", 1'b0, 0, 1'b0, 1);
        way_hit = 2'b01;
        #1 chk("t1_replay_wen", darray_wen, 0);
        chk("t1_replay_way", way_sel, 0);
        chk("t1_replay_respval", memresp_val, 0);
        tick;
        resp_step("t1");

        // 2: write hit way0, then a read miss fills the invalid way1
        req(1'b1, 4'd3);
        way_hit = 2'b01;
        #1 chk("t2_wr_darray_wen", darray_wen, 2'b01);
        chk("t2_wr_src", darray_src_mem, 0);
        chk("t2_wr_dirty_wen", dirty_wen, 1);
        chk("t2_wr_dirty_wdata", dirty_wdata, 1);
        tick;
        resp_step("t2w");
        req(1'b0, 4'd3);
        way_hit = 2'b00; way_dirty = 2'b01;
        #1 chk("t2_miss_wen", darray_wen, 0);
        tick;
        run_mem("t2", 1'b0, 1, 1'b0, 1);
        way_hit = 2'b10;
        #1 chk("t2_replay_way", way_sel, 1);
        tick;
        resp_step("t2r");

        // 3: set full, PLRU points to dirty way0 -> evict then refill way0
        req(1'b0, 4'd3);
        way_hit = 2'b00; way_dirty = 2'b01;
        #1 chk("t3_tag_reqval", mem_req_val, 0);
        tick;
        run_mem("t3e", 1'b1, 0, 1'b0, 1);
        run_mem("t3r", 1'b0, 0, 1'b0, 1);
        way_hit = 2'b01; way_dirty = 2'b00;
        #1 chk("t3_replay_way", way_sel, 0);
        chk("t3_replay_wen", darray_wen, 0);
        tick;
        resp_step("t3");

        // 4: refill on idx 5 with toggling mem_req_rdy and 3-cycle response latency
        req(1'b0, 4'd5);
        way_hit = 2'b00;
        tick;
        run_mem("t4", 1'b0, 0, 1'b1, 3);
        way_hit = 2'b01;
        tick;
        resp_step("t4");

        // 5: hit held in RESP by memresp_rdy=0 for 5 cycles; new requests refused meanwhile
        req(1'b0, 4'd5);
        way_hit = 2'b01;
        tick;
        for (int i = 0; i < 5; i++) begin
            memresp_rdy = 1'b0;
            memreq_val  = 1'b1;
            #1 chk("t5_hold_val", memresp_val, 1);
            chk("t5_hold_reqrdy", memreq_rdy, 0);
            tick;
        end
        memreq_val = 1'b0;
        resp_step("t5");

        // 6: reset during refill beat 2 on idx 7
        req(1'b0, 4'd7);
        way_hit = 2'b00;
        tick;
        mem_req_rdy = 1'b1;
        #1 chk("t6_r0_reqval", mem_req_val, 1);
        tick;
        mem_resp_val = 1'b1;
        #1 chk("t6_b0_wen", darray_wen, 2'b01);
        chk("t6_b0_word", darray_word_sel, 0);
        tick;
        #1 chk("t6_b1_wen", darray_wen, 2'b01);
        chk("t6_b1_word", darray_word_sel, 1);
        tick;
        reset = 1'b0;
        #1 chk("t6_rst_wen", darray_wen, 0);
        chk("t6_rst_twen", tarray_wen, 0);
        chk("t6_rst_dwen", dirty_wen, 0);
        chk("t6_rst_resp_rdy", mem_resp_rdy, 1);
        tick;
        reset = 1'b1; mem_req_rdy = 1'b0;
        #1 chk("t6_stale_memreq_rdy", memreq_rdy, 1);
        chk("t6_stale_resp_rdy", mem_resp_rdy, 1);
        chk("t6_stale_wen", darray_wen, 0);
        chk("t6_stale_twen", tarray_wen, 0);
        chk("t6_stale_reqval", mem_req_val, 0);
        tick;
        mem_resp_val = 1'b0;
        req(1'b0, 4'd7);
        way_hit = 2'b01;
        #1 chk("t6_tag_respval", memresp_val, 0);
        tick;
        #1 chk("t6_miss_reqval", mem_req_val, 1);
        chk("t6_miss_respval", memresp_val, 0);
        run_mem("t6", 1'b0, 0, 1'b0, 1);
        way_hit = 2'b01;
        tick;
        resp_step("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
